exception_unit: RTL

Sequential exception and interrupt controller for the single-cycle processor. It replaces the purely combinational single-line ExtIRQ handling with a parametrised unit that:
- latches NIRQ edge-triggered external requests plus the decoder's not-an-instruction flag;
- arbitrates among them and holds the selected request until the core acknowledges it;
- blocks further exceptions until ERet.

It sits beside the controller. Its exc/estatus outputs feed the datapath exception logic, and ext_iack returns to the interrupt sources.

---
 rtl/exc_pkg.sv | 16 +
 rtl/exception_unit_arbiter.sv | 55 +++++
 rtl/exception_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// Shared types and cause codes for the exception unit.
package exc_pkg;

  localparam int ESTAT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [ESTAT_W-1:0] ESTAT_NONE     = 4'b0000;
  localparam logic [ESTAT_W-1:0] ESTAT_EXTIRQ   = 4'b0001;
  localparam logic [ESTAT_W-1:0] ESTAT_NOTINSTR = 4'b0010;

endpackage

// File: rtl/exception_unit_arbiter.sv
// Picks one eligible irq line: rotating priority with EXC_RR_EN defined,
// otherwise fixed priority with the lowest index winning.
module irq_arbiter #(
  parameter int NIRQ = 4,
  parameter int IDW  = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] eligible,
  input  logic            advance,
  output logic            valid,
  output logic [IDW-1:0]  winner
);

`ifdef EXC_RR_EN
  logic [IDW-1:0] ptr;

  // Search starts at ptr and wraps around the line vector.
  always_comb begin
    int idx;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NIRQ; i++) begin
      idx = (int'(ptr) + i) % NIRQ;
      if (!valid && eligible[idx]) begin
        valid  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (advance)
      ptr <= (winner == IDW'(NIRQ - 1)) ? '0 : winner + 1'b1;
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clk, reset, advance};

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (!valid && eligible[i]) begin
        valid  = 1'b1;
        winner = IDW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/exception_unit.sv
// Exception/interrupt controller: edge-latched irqs plus not-an-instruction,
// held until acknowledged, blocked until eret. EXC_RR_EN selects rotating priority.
module exception_unit
  import exc_pkg::*;
#(
  parameter int NIRQ = 4,
  parameter int IDW  = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NIRQ-1:0]    irq,
  input  logic [NIRQ-1:0]    irq_mask,
  input  logic               not_an_instr,
  input  logic               exc_ack,
  input  logic               eret,
  output logic               exc,
  output logic [ESTAT_W-1:0] estatus,
  output logic [IDW-1:0]     exc_id,
  output logic [NIRQ-1:0]    ext_iack,
  output logic [NIRQ-1:0]    pending,
  output logic               busy
);

  state_e             state, state_n;
  logic [NIRQ-1:0]    irq_q, irq_rise, eligible;
  logic [ESTAT_W-1:0] estatus_r, estatus_n;
  logic [IDW-1:0]     exc_id_r, exc_id_n;
  logic               take_irq, arb_valid, iack_en;
  logic [IDW-1:0]     arb_winner;

  assign irq_rise = irq & ~irq_q;
  assign eligible = pending & ~irq_mask;

  irq_arbiter #(.NIRQ(NIRQ), .IDW(IDW)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible),
    .advance  (take_irq),
    .valid    (arb_valid),
    .winner   (arb_winner)
  );

  always_comb begin
    state_n   = state;
    estatus_n = estatus_r;
    exc_id_n  = exc_id_r;
    take_irq  = 1'b0;
    case (state)
      IDLE: begin
        // The synchronous cause outranks every external line.
        if (not_an_instr) begin
          state_n   = REQ;
          estatus_n = ESTAT_NOTINSTR;
          exc_id_n  = '0;
        end else if (arb_valid) begin
          state_n   = REQ;
          estatus_n = ESTAT_EXTIRQ;
          exc_id_n  = arb_winner;
          take_irq  = 1'b1;
        end
      end
      REQ: begin
        if (exc_ack) state_n = SERVICE;
      end
      SERVICE: begin
        if (eret) begin
          state_n   = IDLE;
          estatus_n = ESTAT_NONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The grant is fixed once in REQ, so a late mask change cannot revoke it.
  assign iack_en  = (state == REQ) && exc_ack && (estatus_r == ESTAT_EXTIRQ) && !reset;
  assign ext_iack = iack_en ? (NIRQ'(1) << exc_id_r) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      irq_q     <= irq;
      pending   <= '0;
      estatus_r <= ESTAT_NONE;
      exc_id_r  <= '0;
    end else begin
      state     <= state_n;
      irq_q     <= irq;
      pending   <= (pending & ~ext_iack) | irq_rise;
      estatus_r <= estatus_n;
      exc_id_r  <= exc_id_n;
    end
  end

  assign exc     = (state == REQ);
  assign busy    = (state != IDLE);
  assign estatus = estatus_r;
  assign exc_id  = exc_id_r;

endmodule
